// File: rtl/control_turnos.sv
// control_turnos: game sequencer for a two-player (human vs PC) naval battle.
// Walks through ship placement, alternating turns with a per-second countdown
// for the human player, a fixed two-cycle settle window after every shot,
// and latched win/lose results. All outputs come straight from flops.
module control_turnos #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] barcos,
  input  logic       barcosColocadosJ,
  input  logic       barcosColocadosPC,
  input  logic       disparo,
  input  logic       disparoPCListo,
  input  logic       flotaJHundida,
  input  logic       flotaPCHundida,
  output logic       colocarHabilitado,
  output logic       colocarPCEn,
  output logic [2:0] barcosSel,
  output logic       disparoJEn,
  output logic       disparoPCEn,
  output logic       turnoJugador,
  output logic       timeout,
  output logic [3:0] segundos,
  output logic       ganaJugador,
  output logic       ganaPC,
  output logic [2:0] estado
);

  localparam int            PW       = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ - 1);
  localparam logic [3:0]    SEG_LOAD = 4'(TURN_SECONDS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLACE_J  = 3'd1,
    PLACE_PC = 3'd2,
    TURN_J   = 3'd3,
    TURN_PC  = 3'd4,
    CHECK    = 3'd5,
    WIN      = 3'd6,
    LOSE     = 3'd7
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          origen_pc;  // who fired the shot being settled in CHECK
  logic          chk_cnt;    // 0 = first CHECK cycle, 1 = second (evaluate)

  assign estado = state;

  // Sequencer: state, turn timer and every registered output. Strobes default
  // low each cycle so none can outlive a single clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      presc             <= '0;
      origen_pc         <= 1'b0;
      chk_cnt           <= 1'b0;
      barcosSel         <= 3'd0;
      segundos          <= 4'd0;
      colocarHabilitado <= 1'b0;
      colocarPCEn       <= 1'b0;
      turnoJugador      <= 1'b0;
      ganaJugador       <= 1'b0;
      ganaPC            <= 1'b0;
      disparoJEn        <= 1'b0;
      disparoPCEn       <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      disparoJEn  <= 1'b0;
      disparoPCEn <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        IDLE: if (start && barcos != 3'd0 && barcos <= 3'd5) begin
          state             <= PLACE_J;
          barcosSel         <= barcos;
          colocarHabilitado <= 1'b1;
        end
        PLACE_J: if (barcosColocadosJ) begin
          state             <= PLACE_PC;
          colocarHabilitado <= 1'b0;
          colocarPCEn       <= 1'b1;
        end
        PLACE_PC: if (barcosColocadosPC) begin
          state        <= TURN_J;
          colocarPCEn  <= 1'b0;
          turnoJugador <= 1'b1;
          segundos     <= SEG_LOAD;
          presc        <= '0;
        end
        TURN_J: begin
          // A shot beats an expiring timer in the same cycle.
          if (disparo) begin
            state        <= CHECK;
            origen_pc    <= 1'b0;
            chk_cnt      <= 1'b0;
            disparoJEn   <= 1'b1;
            turnoJugador <= 1'b0;
            segundos     <= 4'd0;
            presc        <= '0;
          end else if (presc == PRESC_TC) begin
            presc <= '0;
            if (segundos == 4'd1) begin
              state        <= TURN_PC;
              timeout      <= 1'b1;
              disparoPCEn  <= 1'b1;
              turnoJugador <= 1'b0;
              segundos     <= 4'd0;
            end else begin
              segundos <= segundos - 4'd1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        TURN_PC: if (disparoPCListo) begin
          state     <= CHECK;
          origen_pc <= 1'b1;
          chk_cnt   <= 1'b0;
        end
        CHECK: begin
          if (!chk_cnt) begin
            chk_cnt <= 1'b1;
          end else begin
            chk_cnt <= 1'b0;
            if (!origen_pc) begin
              if (flotaPCHundida) begin
                state       <= WIN;
                ganaJugador <= 1'b1;
              end else begin
                state       <= TURN_PC;
                disparoPCEn <= 1'b1;
              end
            end else if (flotaJHundida) begin
              state  <= LOSE;
              ganaPC <= 1'b1;
            end else begin
              state        <= TURN_J;
              turnoJugador <= 1'b1;
              segundos     <= SEG_LOAD;
              presc        <= '0;
            end
          end
        end
        WIN, LOSE: if (start) begin
          state       <= IDLE;
          barcosSel   <= 3'd0;
          ganaJugador <= 1'b0;
          ganaPC      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_turnos.sv
// tb_control_turnos: randomized + directed scoreboard bench. The driver steps a
// game-level reference model and queues the expected outputs; a monitor pops
// one entry per clock and compares against the DUT.
module tb_control_turnos;
  localparam int CF = 4;
  localparam int TS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] barcos = 3'd0;
  logic       barcosColocadosJ = 1'b0, barcosColocadosPC = 1'b0;
  logic       disparo = 1'b0, disparoPCListo = 1'b0;
  logic       flotaJHundida = 1'b0, flotaPCHundida = 1'b0;
  logic       colocarHabilitado, colocarPCEn, disparoJEn, disparoPCEn;
  logic       turnoJugador, timeout, ganaJugador, ganaPC;
  logic [2:0] barcosSel, estado;
  logic [3:0] segundos;

  always #5 clk = ~clk;

  control_turnos #(.CLK_FREQ(CF), .TURN_SECONDS(TS)) dut (
    .clk(clk), .reset(reset), .start(start), .barcos(barcos),
    .barcosColocadosJ(barcosColocadosJ), .barcosColocadosPC(barcosColocadosPC),
    .disparo(disparo), .disparoPCListo(disparoPCListo),
    .flotaJHundida(flotaJHundida), .flotaPCHundida(flotaPCHundida),
    .colocarHabilitado(colocarHabilitado), .colocarPCEn(colocarPCEn),
    .barcosSel(barcosSel), .disparoJEn(disparoJEn), .disparoPCEn(disparoPCEn),
    .turnoJugador(turnoJugador), .timeout(timeout), .segundos(segundos),
    .ganaJugador(ganaJugador), .ganaPC(ganaPC), .estado(estado)
  );

  // flags: {colocarHabilitado, colocarPCEn, turnoJugador, timeout,
  //         disparoJEn, disparoPCEn, ganaJugador, ganaPC}
  typedef struct packed {
    logic [2:0] estado;
    logic [2:0] sel;
    logic [3:0] seg;
    logic [7:0] flags;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0, bad = 0, ncyc = 0;

  // Game-level model: phase, cycles elapsed in the player's turn, cycles spent
  // settling, and the one-shot events produced by the last step.
  int       m_ph, m_elapsed, m_chk;
  bit [2:0] m_sel;
  bit       m_opc, m_jen, m_pcen, m_to;

  function automatic obs_t act();
    obs_t o;
    o.estado = estado;
    o.sel    = barcosSel;
    o.seg    = segundos;
    o.flags  = {colocarHabilitado, colocarPCEn, turnoJugador, timeout,
                disparoJEn, disparoPCEn, ganaJugador, ganaPC};
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.estado = 3'(m_ph);
    o.sel    = m_sel;
    o.seg    = (m_ph == 3) ? 4'(TS - m_elapsed / CF) : 4'd0;
    o.flags  = {m_ph == 1, m_ph == 2, m_ph == 3, m_to, m_jen, m_pcen,
                m_ph == 6, m_ph == 7};
    return o;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_elapsed = 0; m_chk = 0; m_sel = 3'd0;
    m_opc = 1'b0; m_jen = 1'b0; m_pcen = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit [2:0] b, input bit cj, input bit cpc,
                            input bit d, input bit l, input bit fj, input bit fp);
    m_jen = 1'b0; m_pcen = 1'b0; m_to = 1'b0;
    case (m_ph)
      0: if (s && b >= 3'd1 && b <= 3'd5) begin m_ph = 1; m_sel = b; end
      1: if (cj) m_ph = 2;
      2: if (cpc) begin m_ph = 3; m_elapsed = 0; end
      3: if (d) begin
           m_ph = 5; m_chk = 0; m_opc = 1'b0; m_jen = 1'b1;
         end else begin
           m_elapsed++;
           if (m_elapsed == TS * CF) begin m_ph = 4; m_to = 1'b1; m_pcen = 1'b1; end
         end
      4: if (l) begin m_ph = 5; m_chk = 0; m_opc = 1'b1; end
      5: begin
           m_chk++;
           if (m_chk == 2) begin
             if (!m_opc) begin
               if (fp) m_ph = 6; else begin m_ph = 4; m_pcen = 1'b1; end
             end else begin
               if (fj) m_ph = 7; else begin m_ph = 3; m_elapsed = 0; end
             end
           end
         end
      default: if (s) begin m_ph = 0; m_sel = 3'd0; end
    endcase
  endtask

  task automatic check(input string name, input obs_t a, input obs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got estado=%0d sel=%0d seg=%0d flags=%b, want estado=%0d sel=%0d seg=%0d flags=%b",
               name, a.estado, a.sel, a.seg, a.flags, e.estado, e.sel, e.seg, e.flags);
    end
  endtask

  task automatic cyc(input bit s, input bit [2:0] b, input bit cj, input bit cpc,
                     input bit d, input bit l, input bit fj, input bit fp);
    @(negedge clk);
    reset = 1'b1; start = s; barcos = b; barcosColocadosJ = cj; barcosColocadosPC = cpc;
    disparo = d; disparoPCListo = l; flotaJHundida = fj; flotaPCHundida = fp;
    model_step(s, b, cj, cpc, d, l, fj, fp);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 3'd0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset dropped between edges must clear everything before the next edge.
  task automatic async_rst(input string name);
    @(negedge clk);
    #2;
    reset = 1'b0; start = 1'b0; disparo = 1'b0; disparoPCListo = 1'b0;
    barcosColocadosJ = 1'b0; barcosColocadosPC = 1'b0;
    #1;
    model_reset();
    check(name, act(), model_obs());
    exp_q.push_back(model_obs());
  endtask

  // Monitor: one registered output sample per clock, compared to the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e;
        e = exp_q.pop_front();
        check($sformatf("cycle %0d", ncyc), act(), e);
      end
      ncyc++;
    end
  end

  initial begin
    model_reset();
    #3;
    check("reset state", act(), model_obs());

    // invalid ship counts are ignored
    cyc(1, 3'd0, 0, 0, 0, 0, 0, 0);
    cyc(1, 3'd6, 0, 0, 0, 0, 0, 0);
    cyc(1, 3'd7, 0, 0, 0, 0, 0, 0);
    // placement, then full timeout
    cyc(1, 3'd3, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 3'd0, 1, 0, 0, 0, 0, 0);
    cyc(1, 3'd1, 0, 1, 0, 0, 0, 0);
    idle(12);
    idle(1);
    // PC shot, fleet alive -> back to player with reloaded timer
    cyc(0, 3'd0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // player shot sinks PC fleet -> WIN, then start -> IDLE
    cyc(0, 3'd0, 0, 0, 1, 0, 0, 1);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 1);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(1, 3'd2, 0, 0, 0, 0, 0, 0);
    // second game: PC shot accepted in first TURN_PC cycle, sinks player -> LOSE
    cyc(1, 3'd5, 0, 0, 0, 0, 0, 0);
    cyc(0, 3'd0, 1, 0, 0, 0, 0, 0);
    cyc(0, 3'd0, 0, 1, 0, 0, 0, 0);
    cyc(0, 3'd0, 0, 0, 1, 0, 0, 0);
    idle(2);
    cyc(0, 3'd0, 0, 0, 0, 1, 1, 0);
    cyc(0, 3'd0, 0, 0, 0, 0, 1, 0);
    cyc(0, 3'd0, 0, 0, 0, 0, 1, 0);
    idle(1);
    cyc(1, 3'd0, 0, 0, 0, 0, 0, 0);
    // third game: shot on the expiring cycle wins over timeout, reset mid-CHECK
    cyc(1, 3'd2, 0, 0, 0, 0, 0, 0);
    cyc(0, 3'd0, 1, 0, 0, 0, 0, 0);
    cyc(0, 3'd0, 0, 1, 0, 0, 0, 0);
    idle(11);
    cyc(0, 3'd0, 0, 0, 1, 0, 0, 0);
    idle(2);
    cyc(0, 3'd0, 0, 0, 0, 1, 0, 0);
    idle(1);
    async_rst("reset mid-check");
    idle(2);

    // randomized play with occasional asynchronous resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) async_rst("random reset");
      else cyc($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
